// File: rtl/tdp_bram_pkg.sv
// Shared constants and types for the byte-enable true dual-port RAM.
package tdp_bram_pkg;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

endpackage

// File: rtl/tdp_bram_be_if.sv
// Request/response bundle for both ports of tdp_bram_be.
interface tdp_bram_be_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NBYTES     = DATA_WIDTH / 8
);
  logic                  en0;
  logic                  en1;
  logic [NBYTES-1:0]     we0;
  logic [NBYTES-1:0]     we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;
  logic [DATA_WIDTH-1:0] q0;
  logic [DATA_WIDTH-1:0] q1;
  logic                  qv0;
  logic                  qv1;
  logic                  collision;
  logic                  init_busy;

  modport master (
    output en0, en1, we0, we1, addr0, addr1, d0, d1,
    input  q0, q1, qv0, qv1, collision, init_busy
  );

  modport slave (
    input  en0, en1, we0, we1, addr0, addr1, d0, d1,
    output q0, q1, qv0, qv1, collision, init_busy
  );
endinterface

// File: rtl/tdp_init_ctrl.sv
// Post-reset clear sequencer: walks every address once, driving a zero write.
module tdp_init_ctrl
  import tdp_bram_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_SIZE - 1);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? StClear : StIdle;
      cnt_q   <= '0;
      busy_q  <= (INIT_CLEAR != 0);
    end else begin
      case (state_q)
        StClear: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == LastAddr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = busy_q;
  assign clr_we    = (state_q == StClear);
  assign clr_addr  = cnt_q;

endmodule

// File: rtl/tdp_bram_be.sv
// True dual-port RAM with byte enables, per-port read-during-write mode,
// cross-port collision resolution and optional output register.
module tdp_bram_be
  import tdp_bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int unsigned NBYTES     = DATA_WIDTH / 8,
  parameter int unsigned OUT_REG    = 1,
  parameter int unsigned RDW_MODE0  = RDW_WRITE_FIRST,
  parameter int unsigned RDW_MODE1  = RDW_WRITE_FIRST,
  parameter int unsigned INIT_CLEAR = 1
) (
  input logic          clk,
  input logic          rst_n,
  tdp_bram_be_if.slave bus
);

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [NBYTES-1:0]     be);
    merge_lanes = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  logic [DATA_WIDTH-1:0] ram [MEM_SIZE];

  logic                  init_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  tdp_init_ctrl #(
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_CLEAR(INIT_CLEAR)
  ) u_init_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic                  en0_e, en1_e, wr0, wr1, same_addr, wr1_ok, coll_d;
  logic [DATA_WIDTH-1:0] old0, old1, new0, new1;

  assign en0_e     = bus.en0 & ~init_busy;
  assign en1_e     = bus.en1 & ~init_busy;
  assign wr0       = en0_e & (|bus.we0);
  assign wr1       = en1_e & (|bus.we1);
  assign same_addr = (bus.addr0 == bus.addr1);
  // Port 0 owns the whole word on a write/write clash, even for disjoint lanes.
  assign wr1_ok    = wr1 & ~(wr0 & same_addr);
  assign coll_d    = en0_e & en1_e & same_addr & (wr0 | wr1);
  assign old0      = ram[bus.addr0];
  assign old1      = ram[bus.addr1];
  assign new0      = merge_lanes(old0, bus.d0, bus.we0);
  assign new1      = merge_lanes(old1, bus.d1, bus.we1);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_addr] <= '0;
    end else begin
      if (wr0)    ram[bus.addr0] <= new0;
      if (wr1_ok) ram[bus.addr1] <= new1;
    end
  end

  logic [DATA_WIDTH-1:0] q0_s1_q, q1_s1_q, q0_d, q1_d;
  logic                  qv0_s1_q, qv1_s1_q, qv0_d, qv1_d, coll_q;

  // Same-port read-during-write; the old word read here is pre-write, which also
  // gives a cross-port reader the old data.
  always_comb begin
    q0_d  = q0_s1_q;
    qv0_d = 1'b0;
    if (en0_e) begin
      if (!wr0) begin
        q0_d  = old0;
        qv0_d = 1'b1;
      end else if (RDW_MODE0 == RDW_WRITE_FIRST) begin
        q0_d  = new0;
        qv0_d = 1'b1;
      end else if (RDW_MODE0 == RDW_READ_FIRST) begin
        q0_d  = old0;
        qv0_d = 1'b1;
      end
    end
  end

  always_comb begin
    q1_d  = q1_s1_q;
    qv1_d = 1'b0;
    if (en1_e) begin
      if (!wr1) begin
        q1_d  = old1;
        qv1_d = 1'b1;
      end else if (RDW_MODE1 == RDW_WRITE_FIRST) begin
        q1_d  = new1;
        qv1_d = 1'b1;
      end else if (RDW_MODE1 == RDW_READ_FIRST) begin
        q1_d  = old1;
        qv1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q0_s1_q  <= '0;
      q1_s1_q  <= '0;
      qv0_s1_q <= 1'b0;
      qv1_s1_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      q0_s1_q  <= q0_d;
      q1_s1_q  <= q1_d;
      qv0_s1_q <= qv0_d;
      qv1_s1_q <= qv1_d;
      coll_q   <= coll_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q0_s2_q, q1_s2_q;
    logic                  qv0_s2_q, qv1_s2_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q0_s2_q  <= '0;
        q1_s2_q  <= '0;
        qv0_s2_q <= 1'b0;
        qv1_s2_q <= 1'b0;
      end else begin
        q0_s2_q  <= q0_s1_q;
        q1_s2_q  <= q1_s1_q;
        qv0_s2_q <= qv0_s1_q;
        qv1_s2_q <= qv1_s1_q;
      end
    end

    assign bus.q0  = q0_s2_q;
    assign bus.q1  = q1_s2_q;
    assign bus.qv0 = qv0_s2_q;
    assign bus.qv1 = qv1_s2_q;
  end else begin : g_no_out_reg
    assign bus.q0  = q0_s1_q;
    assign bus.q1  = q1_s1_q;
    assign bus.qv0 = qv0_s1_q;
    assign bus.qv1 = qv1_s1_q;
  end

  assign bus.collision = coll_q;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_tdp_bram_be.sv
// Bench for tdp_bram_be: two configurations share one stimulus stream and are
// compared every cycle against a word-level model, plus directed literal checks.
module tb_tdp_bram_be;
  localparam int unsigned DW = 32;
  localparam int unsigned MS = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en0, en1;
  logic [NB-1:0] we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] d0, d1;

  tdp_bram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  tdp_bram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  assign ifa.en0 = en0;    assign ifb.en0 = en0;
  assign ifa.en1 = en1;    assign ifb.en1 = en1;
  assign ifa.we0 = we0;    assign ifb.we0 = we0;
  assign ifa.we1 = we1;    assign ifb.we1 = we1;
  assign ifa.addr0 = addr0; assign ifb.addr0 = addr0;
  assign ifa.addr1 = addr1; assign ifb.addr1 = addr1;
  assign ifa.d0 = d0;      assign ifb.d0 = d0;
  assign ifa.d1 = d1;      assign ifb.d1 = d1;

  // A: latency 2, port0 write-first, port1 read-first. B: latency 1, both no-change.
  tdp_bram_be #(
    .DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .OUT_REG(1),
    .RDW_MODE0(0), .RDW_MODE1(1), .INIT_CLEAR(1)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa.slave)
  );

  tdp_bram_be #(
    .DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .OUT_REG(0),
    .RDW_MODE0(2), .RDW_MODE1(2), .INIT_CLEAR(1)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb.slave)
  );

  int checks = 0;
  int failures = 0;

  function automatic void cmp(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mem [MS];
  bit            busy;
  int            cidx;
  bit            started = 1'b0;
  logic [DW-1:0] lq [2][2];   // last q value per instance/port
  bit            pv [2];      // instance A valid from the previous edge
  logic [DW-1:0] eq [2][2];
  bit            ev [2][2];
  bit            ecoll;
  bit            ebusy;

  function automatic void port_res(input int md, input bit e, input bit w,
                                   input logic [DW-1:0] old, input logic [DW-1:0] merged,
                                   input logic [DW-1:0] last,
                                   output logic [DW-1:0] nq, output bit nv);
    nq = last;
    nv = 1'b0;
    if (e && !w) begin
      nq = old; nv = 1'b1;
    end else if (e && w && md == 0) begin
      nq = merged; nv = 1'b1;
    end else if (e && w && md == 1) begin
      nq = old; nv = 1'b1;
    end
  endfunction

  always @(posedge clk) begin : model
    bit            e [2];
    bit            w [2];
    logic [DW-1:0] old [2];
    logic [DW-1:0] nw [2];
    logic [DW-1:0] nq;
    bit            nv;
    int            md;
    if (rst_n === 1'b0) begin
      busy = 1'b1; cidx = 0; ebusy = 1'b1; ecoll = 1'b0; started = 1'b1;
      for (int k = 0; k < 2; k++) begin
        pv[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          lq[k][p] = '0; eq[k][p] = '0; ev[k][p] = 1'b0;
        end
      end
    end else if (started) begin
      e[0] = en0 && !busy;
      e[1] = en1 && !busy;
      w[0] = e[0] && (we0 != 0);
      w[1] = e[1] && (we1 != 0);
      old[0] = mem[addr0];
      old[1] = mem[addr1];
      nw[0] = old[0];
      nw[1] = old[1];
      for (int i = 0; i < NB; i++) begin
        if (we0[i]) nw[0][8*i +: 8] = d0[8*i +: 8];
        if (we1[i]) nw[1][8*i +: 8] = d1[8*i +: 8];
      end
      ecoll = e[0] && e[1] && (addr0 == addr1) && (w[0] || w[1]);
      for (int p = 0; p < 2; p++) begin
        // A uses mode p (0 write-first, 1 read-first); B is no-change (2).
        md = p;
        port_res(md, e[p], w[p], old[p], nw[p], lq[0][p], nq, nv);
        eq[0][p] = lq[0][p];
        ev[0][p] = pv[p];
        lq[0][p] = nq;
        pv[p]    = nv;
        md = 2;
        port_res(md, e[p], w[p], old[p], nw[p], lq[1][p], nq, nv);
        lq[1][p] = nq;
        eq[1][p] = nq;
        ev[1][p] = nv;
      end
      if (busy) begin
        mem[cidx] = '0;
        if (cidx == MS - 1) busy = 1'b0;
        else cidx++;
      end else begin
        if (w[0]) mem[addr0] = nw[0];
        if (w[1] && !(w[0] && addr0 == addr1)) mem[addr1] = nw[1];
      end
      ebusy = busy;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("a.q0", ifa.q0, eq[0][0]);
      cmp("a.qv0", DW'(ifa.qv0), DW'(ev[0][0]));
      cmp("a.q1", ifa.q1, eq[0][1]);
      cmp("a.qv1", DW'(ifa.qv1), DW'(ev[0][1]));
      cmp("a.collision", DW'(ifa.collision), DW'(ecoll));
      cmp("a.init_busy", DW'(ifa.init_busy), DW'(ebusy));
      cmp("b.q0", ifb.q0, eq[1][0]);
      cmp("b.qv0", DW'(ifb.qv0), DW'(ev[1][0]));
      cmp("b.q1", ifb.q1, eq[1][1]);
      cmp("b.qv1", DW'(ifb.qv1), DW'(ev[1][1]));
      cmp("b.collision", DW'(ifb.collision), DW'(ecoll));
      cmp("b.init_busy", DW'(ifb.init_busy), DW'(ebusy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en0 = 1'b0; en1 = 1'b0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (ifa.init_busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // 1: clear duration and zeroed contents
    wait_clear(n);
    cmp("t1_busy_cycles", DW'(n), DW'(16));
    for (int a = 0; a < MS; a++) begin
      en1 = 1'b1; addr1 = AW'(a);
      tick();
    end
    idle();
    en0 = 1'b1; addr0 = 4'd0;
    tick();
    idle();
    cmp("t1_b_q0", ifb.q0, 32'h0);
    cmp("t1_b_qv0", DW'(ifb.qv0), 32'd1);
    tick();
    cmp("t1_a_qv0", DW'(ifa.qv0), 32'd1);

    // 2: byte-lane merge
    en0 = 1'b1; we0 = 4'hF; addr0 = 4'd5; d0 = 32'hAABBCCDD;
    tick();
    we0 = 4'b0010; d0 = 32'h00001100;
    tick();
    idle();
    en1 = 1'b1; addr1 = 4'd5;
    tick();
    idle();
    cmp("t2_b_q1", ifb.q1, 32'hAABB11DD);
    tick();
    cmp("t2_a_q1", ifa.q1, 32'hAABB11DD);
    cmp("t2_a_qv1", DW'(ifa.qv1), 32'd1);

    // 3: same-port write after write in every RDW mode
    en0 = 1'b1; we0 = 4'hF; addr0 = 4'd3; d0 = 32'h11111111;
    en1 = 1'b1; we1 = 4'hF; addr1 = 4'd4; d1 = 32'h11111111;
    tick();
    d0 = 32'h22222222; d1 = 32'h22222222;
    tick();
    idle();
    cmp("t3_b_nochange_q0", ifb.q0, 32'h0);
    cmp("t3_b_nochange_qv0", DW'(ifb.qv0), 32'd0);
    cmp("t3_a_wf_first_q0", ifa.q0, 32'h11111111);
    tick();
    cmp("t3_a_wf_q0", ifa.q0, 32'h22222222);
    cmp("t3_a_wf_qv0", DW'(ifa.qv0), 32'd1);
    cmp("t3_a_rf_q1", ifa.q1, 32'h11111111);
    cmp("t3_a_rf_qv1", DW'(ifa.qv1), 32'd1);

    // 4: write/write collision, port 0 wins
    en0 = 1'b1; we0 = 4'hF; addr0 = 4'd7; d0 = 32'h1;
    en1 = 1'b1; we1 = 4'hF; addr1 = 4'd7; d1 = 32'h2;
    tick();
    idle();
    cmp("t4_a_collision", DW'(ifa.collision), 32'd1);
    cmp("t4_b_collision", DW'(ifb.collision), 32'd1);
    en1 = 1'b1; addr1 = 4'd7;
    tick();
    idle();
    cmp("t4_b_q1", ifb.q1, 32'h1);

    // 5: read/write collision, reader sees the old word
    en0 = 1'b1; we0 = 4'hF; addr0 = 4'd9; d0 = 32'h5A;
    tick();
    we0 = 4'h0;
    en1 = 1'b1; we1 = 4'hF; addr1 = 4'd9; d1 = 32'hA5;
    tick();
    idle();
    cmp("t5_b_q0", ifb.q0, 32'h5A);
    cmp("t5_collision", DW'(ifb.collision), 32'd1);
    tick();
    cmp("t5_a_q0", ifa.q0, 32'h5A);
    cmp("t5_collision_gone", DW'(ifa.collision), 32'd0);
    en0 = 1'b1; addr0 = 4'd9;
    tick();
    idle();
    cmp("t5_b_q0_after", ifb.q0, 32'hA5);

    // 6: reset mid-clear restarts; requests during clear are ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en0 = 1'b1; we0 = 4'hF; addr0 = 4'd2; d0 = 32'hFFFFFFFF;
    en1 = 1'b1; addr1 = 4'd2;
    wait_clear(n);
    idle();
    cmp("t6_busy_cycles", DW'(n), DW'(16));
    cmp("t6_qv1_during_clear", DW'(ifb.qv1), 32'd0);
    en0 = 1'b1; addr0 = 4'd2;
    tick();
    idle();
    cmp("t6_b_q0", ifb.q0, 32'h0);

    // Random traffic over a tiny address space to provoke collisions
    for (int c = 0; c < 2500; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      en0   = ($urandom_range(0, 3) != 0);
      en1   = ($urandom_range(0, 3) != 0);
      we0   = $urandom_range(0, 1) ? NB'($urandom) : '0;
      we1   = $urandom_range(0, 1) ? NB'($urandom) : '0;
      addr0 = AW'($urandom);
      addr1 = $urandom_range(0, 2) == 0 ? addr0 : AW'($urandom);
      d0    = $urandom;
      d1    = $urandom;
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdp_bram_be.md
Name: tdp_bram_be

Overview:
Second-generation true dual-port block RAM with per-byte write enables and an optional output register stage. Read-during-write mode is selectable per port, and same-address cross-port collisions are detected and resolved. A built-in clear sequencer zeroes the array after reset. It is the storage primitive under the BRAM controller and drop-in wider and deeper than the first-generation dual-port RAM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
MEM_SIZE, 4096, number of words; addresses 0..MEM_SIZE-1.
ADDR_WIDTH, $clog2(MEM_SIZE), address width.
NBYTES, DATA_WIDTH/8, derived byte-lane count; not to be overridden.
OUT_REG, 1, 0 = read latency 1 cycle; 1 = extra output register, latency 2.
RDW_MODE0, 0, port-0 same-port read-during-write: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE.
RDW_MODE1, 0, same as RDW_MODE0 for port 1.
INIT_CLEAR, 1, 1 = zero the whole array after every reset; 0 = no clear, contents undefined.

Ports:
clk  in  1  single clock, all logic posedge.
rst_n  in  1  synchronous active-low reset.
en0, en1  in  1  port enable.
we0, we1  in  NBYTES  byte write enables; any bit set makes the access a write.
addr0, addr1  in  ADDR_WIDTH  word address.
d0, d1  in  DATA_WIDTH  write data; lane i = bits 8i+7:8i.
q0, q1  out  DATA_WIDTH  read data.
qv0, qv1  out  1  read data valid, aligned with q.
collision  out  1  one-cycle pulse flagging a same-address cross-port conflict.
init_busy  out  1  clear in progress; port requests ignored.

Behaviour:
- Reset (rst_n=0 at posedge): q0=q1=0, qv0=qv1=0, collision=0, init_busy=INIT_CLEAR, clear counter=0. Memory contents are not reset by rst_n directly.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR if INIT_CLEAR=1, else IDLE.
  - CLEAR writes 0 to address cnt each cycle and increments cnt.
  - At cnt=MEM_SIZE-1 it writes, then goes to IDLE. init_busy drops the following cycle.
  - CLEAR lasts exactly MEM_SIZE cycles.
  - Reset during CLEAR restarts at address 0.
  - While init_busy=1, en0/en1 are treated as 0: no writes, qv stays 0, no collision.
- Write: for each lane i with we[i]=1, ram[addr][lane i] <= d[lane i]. Other lanes are untouched.
- Read (en=1, we=0): the array is sampled at posedge T.
  - OUT_REG=0: q and qv=1 update at T+1.
  - OUT_REG=1: they update at T+2.
  - qv is 0 on any cycle without a read result.
  - q holds its last value when qv=0, except in WRITE_FIRST/READ_FIRST writes, which update q.
- Same-port write (RDW mode):
  - WRITE_FIRST: q = merged new word (old word with enabled lanes replaced), qv=1.
  - READ_FIRST: q = old word, qv=1.
  - NO_CHANGE: q holds, qv=0.
- Cross-port, both en=1, addr0==addr1, at least one write:
  - Write/write: port 0 wins entirely and port 1's write is dropped, even for disjoint lanes.
  - Read/write: the reader gets the old word.
  - collision=1 at T+1 regardless of OUT_REG; otherwise 0.
- Different addresses: the ports are fully independent.
- Pipeline: with OUT_REG=1, the register stage advances every cycle; there is no backpressure.

Decomposition:
- Package tdp_bram_pkg: RDW_WRITE_FIRST=0, RDW_READ_FIRST=1, RDW_NO_CHANGE=2; clear FSM state encoding.
- Sub-module tdp_init_ctrl: clear FSM, counter, init_busy, and clear-write address/enable muxed onto port 0.
- Array, byte-lane merge, RDW logic and collision detect stay in the top level.

Test Plan:
1. INIT_CLEAR=1, rst_n low 2 cycles then high, MEM_SIZE=16 -> init_busy high exactly 16 cycles. Every address then reads 0 with qv=1 at latency 1+OUT_REG.
2. Port 0 writes 0xAABBCCDD to addr 5, then we0=4'b0010 with d0=0x00001100 -> port 1 read of addr 5 returns 0xAABB11DD two cycles later (OUT_REG=1).
3. Port 0 write-after-write to addr 3 (0x11111111, then 0x22222222 with we0=4'hF); RDW_MODE0 = 0/1/2 -> q0 = 0x22222222 qv0=1 / q0 = 0x11111111 qv0=1 / q0 unchanged qv0=0.
4. Both ports write addr 7 same cycle (d0=0x1, d1=0x2) -> collision=1 next cycle; subsequent read of addr 7 returns 0x1.
5. Addr 9 holds 0x5A; port 0 reads while port 1 writes 0xA5 to addr 9 -> q0=0x5A, collision=1; next read of addr 9 returns 0xA5.
6. Assert rst_n low at clear address 8, release -> clear restarts at 0, init_busy high MEM_SIZE more cycles. Requests issued during init_busy have no effect and produce qv=0.
